mul_hilo_stage: RTL and testbench
=================================

Name: mul_hilo_stage

Overview:
Sequential wrapper around the combinational signed MUL32 multiplier. It latches operands, runs them through MUL32, retimes the 64-bit product through LAT register stages, and commits it to the architectural HI/LO registers. It also serves MTHI/MTLO direct writes and MFHI/MFLO reads. The datapath control unit drives it; HI/LO outputs feed the register-file write-back mux.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH. MUL32 is instantiated only for WIDTH=32.
LAT, 2, edges from operand acceptance to HI/LO commit; legal range 1..4; any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
nRst  input  1  asynchronous active-low reset
start_i  input  1  request: multiply a_i by b_i
start_ready_o  output  1  high when a request can be accepted (= ~busy_o)
a_i  input  WIDTH  signed multiplicand
b_i  input  WIDTH  signed multiplier
busy_o  output  1  multiply in flight
done_o  output  1  one-cycle pulse: HI/LO now hold a new product
hi_we_i  input  1  MTHI: write wr_data_i to HI
lo_we_i  input  1  MTLO: write wr_data_i to LO
wr_data_i  input  WIDTH  direct-write data
wr_err_o  output  1  one-cycle pulse: a direct write was dropped
hi_o  output  WIDTH  HI register (product[63:32])
lo_o  output  WIDTH  LO register (product[31:0])

Behaviour:
- Reset (nRst low, asynchronous, any state): hi_o=0, lo_o=0, busy_o=0, done_o=0, wr_err_o=0, operand regs=0, pipe regs=0, counter=0, FSM=IDLE. Takes effect without a clock edge. An in-flight multiply is discarded and never commits.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on an edge with start_i && start_ready_o. On that edge a_i and b_i are latched into the operand regs and the counter is loaded with LAT-1.
  - RUN: each edge advances the product pipe one stage and decrements the counter. On the edge where the counter equals 0, HI/LO take the pipe output and the FSM returns to IDLE.
- Pipe: the MUL32 inputs are the operand regs. The MUL32 output passes through LAT-1 register stages. With LAT=1, HI/LO load the MUL32 output directly.
- Latency: request accepted at edge k; HI/LO updated at edge k+LAT.
- busy_o: high from after edge k through edge k+LAT.
- done_o: high for exactly the cycle following edge k+LAT.
- start_i while busy_o=1: not accepted and no state change; the requester holds start_i. Back-to-back: a new request may be accepted on the first cycle busy_o=0, i.e. the same cycle done_o is high.
- Arithmetic: two's-complement signed, full 64-bit product, no truncation or saturation. {hi_o,lo_o} must equal $signed(a)*$signed(b) for all inputs, including 0x80000000 cases.
- Direct writes:
  - Accepted only when busy_o=0 and no start is accepted on the same edge.
  - hi_we_i and lo_we_i may both be high; both registers then take wr_data_i.
  - A direct write while busy_o=1, or coinciding with start acceptance, is dropped; wr_err_o pulses for one cycle and HI/LO are unchanged except by the multiply.
- hi_o/lo_o are held registers, stable except on the commit edge or an accepted direct write. Readers must wait on busy_o; no forwarding.

Test Plan:
- Reset mid-RUN: start 5*7 (LAT=2), assert nRst low 1 cycle after accept -> all outputs 0 immediately; done_o never pulses; HI/LO stay 0.
- Corner products:
  - a=0x80000000, b=0x7FFFFFFF -> HI=0xC0000000, LO=0x80000000, done_o exactly LAT edges after accept.
  - a=b=0x80000000 -> 0x40000000_00000000.
  - a=b=0x7FFFFFFF -> 0x3FFFFFFF_00000001.
  - a=b=0xFFFFFFFF -> 0x00000000_00000001.
- Sweep: a=0x80000000, b=0..4095, back-to-back starts (start issued the cycle done_o is high) -> each result equals the signed reference {b?-b<<31}; e.g. b=3 -> 0xFFFFFFFE_80000000. Gap-free acceptance every LAT+1 cycles.
- Stall: hold start_i with a=2, b=3 while busy -> accepted only once busy_o falls; exactly one done_o per accepted request; HI/LO=0x0/0x6.
- Direct writes: idle hi_we_i=lo_we_i=1, wr_data_i=0xDEADBEEF -> HI=LO=0xDEADBEEF next edge. Same write during RUN -> wr_err_o pulse, HI/LO end with the product.
- Repeat corner and back-to-back scenarios for LAT=1 and LAT=4 -> latency matches LAT exactly.

Source files
------------

// File: rtl/mul_hilo_stage.sv
// mul_hilo_stage: sequential wrapper around the signed MUL32 multiplier.
// Latches operands, retimes the 2*WIDTH product through LAT-1 pipe stages,
// commits it to the HI/LO registers, and serves MTHI/MTLO direct writes.
//
// Ports:
//   clk, nRst      - rising-edge clock, asynchronous active-low reset
//   start_i        - multiply request (a_i * b_i), held by the requester
//   start_ready_o  - request can be accepted (~busy_o)
//   a_i, b_i       - signed operands
//   busy_o         - multiply in flight
//   done_o         - one-cycle pulse: HI/LO hold a new product
//   hi_we_i/lo_we_i, wr_data_i - direct writes to HI/LO
//   wr_err_o       - one-cycle pulse: a direct write was dropped
//   hi_o, lo_o     - HI/LO registers (product upper/lower halves)
module mul_hilo_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 2
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_err_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Latency outside 1..4 cannot be honoured by the counter/pipe.
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("mul_hilo_stage: LAT must be in 1..4");
  end

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    pipe_out;
  logic             start_acc;
  logic             commit;
  logic             wr_req;
  logic             wr_ok;

  assign start_acc = start_i && (state_q == S_IDLE);
  assign commit    = (state_q == S_RUN) && (cnt_q == '0);
  assign wr_req    = hi_we_i || lo_we_i;
  // Direct writes lose to both an in-flight multiply and a same-edge start.
  assign wr_ok     = wr_req && (state_q == S_IDLE) && !start_acc;

  assign busy_o        = (state_q == S_RUN);
  assign start_ready_o = ~busy_o;

  // MUL32 core: full-width two's-complement product of the operand regs.
  assign prod = PW'($signed({{WIDTH{op_a_q[WIDTH-1]}}, op_a_q}) *
                    $signed({{WIDTH{op_b_q[WIDTH-1]}}, op_b_q}));

  // Product retiming: LAT-1 register stages, advanced on every RUN edge.
  if (LAT == 1) begin : g_pipe_none
    assign pipe_out = prod;
  end else begin : g_pipe
    logic [PW-1:0] pipe_q [LAT-1];
    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        for (int i = 0; i < int'(LAT) - 1; i++) pipe_q[i] <= '0;
      end else if (state_q == S_RUN) begin
        pipe_q[0] <= prod;
        for (int i = 1; i < int'(LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign pipe_out = pipe_q[LAT-2];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RUN;
      S_RUN:   if (commit)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands, countdown, HI/LO and status pulses.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
      done_o   <= 1'b0;
      wr_err_o <= 1'b0;
    end else begin
      done_o   <= commit;
      wr_err_o <= wr_req && !wr_ok;
      if (start_acc) begin
        op_a_q <= a_i;
        op_b_q <= b_i;
        cnt_q  <= CNT_W'(LAT - 1);
      end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        hi_o <= pipe_out[PW-1:WIDTH];
        lo_o <= pipe_out[WIDTH-1:0];
      end else if (wr_ok) begin
        if (hi_we_i) hi_o <= wr_data_i;
        if (lo_we_i) lo_o <= wr_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mul_hilo_stage.sv
// Directed bench for mul_hilo_stage: three instances at LAT=1, 2, 4 share
// operands, direct-write inputs and reset; each has its own start.
module tb_mul_hilo_stage;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start [3];
  logic [31:0] a, b, wr_data;
  logic        hi_we, lo_we;
  logic        rdy [3], busy [3], done [3], werr [3];
  logic [31:0] hi [3], lo [3];

  int lats [3] = '{1, 2, 4};
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mul_hilo_stage #(.WIDTH(32), .LAT(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk          (clk),
      .nRst         (nRst),
      .start_i      (start[g]),
      .start_ready_o(rdy[g]),
      .a_i          (a),
      .b_i          (b),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .hi_we_i      (hi_we),
      .lo_we_i      (lo_we),
      .wr_data_i    (wr_data),
      .wr_err_o     (werr[g]),
      .hi_o         (hi[g]),
      .lo_o         (lo[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start all three instances together and follow each through its latency.
  task automatic corner(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] ev);
    a = av;
    b = bv;
    for (int d = 0; d < 3; d++) start[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      chk($sformatf("corner_busy0_d%0d", d), 64'(busy[d]), 64'd1);
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("corner_busy_d%0d_j%0d", d, j), 64'(busy[d]), 64'(j < lats[d]));
        chk($sformatf("corner_done_d%0d_j%0d", d, j), 64'(done[d]), 64'(j == lats[d]));
        if (j == lats[d])
          chk($sformatf("corner_prod_d%0d_%h_%h", d, av, bv), {hi[d], lo[d]}, ev);
      end
    end
  endtask

  // Back-to-back a=0x80000000 * b sweep; each new start lands on the done cycle.
  task automatic sweep(input int d, input int n);
    logic [63:0] ev;
    a = 32'h8000_0000;
    for (int i = 0; i < n; i++) begin
      b = 32'(i);
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      chk($sformatf("sweep_busy_d%0d_b%0d", d, i), 64'(busy[d]), 64'd1);
      for (int j = 1; j <= lats[d]; j++) begin
        tick();
        if (j < lats[d])
          chk($sformatf("sweep_early_d%0d_b%0d", d, i), 64'(done[d]), 64'd0);
      end
      ev = 64'd0 - (64'(i) << 31);
      chk($sformatf("sweep_done_d%0d_b%0d", d, i), 64'(done[d]), 64'd1);
      chk($sformatf("sweep_rdy_d%0d_b%0d", d, i), 64'(rdy[d]), 64'd1);
      chk($sformatf("sweep_prod_d%0d_b%0d", d, i), {hi[d], lo[d]}, ev);
    end
  endtask

  initial begin
    nRst = 1'b0;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    a = '0; b = '0; wr_data = '0; hi_we = 1'b0; lo_we = 1'b0;

    // Reset state.
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_hilo_d%0d", d), {hi[d], lo[d]}, 64'd0);
      chk($sformatf("rst_busy_d%0d", d), 64'(busy[d]), 64'd0);
      chk($sformatf("rst_done_d%0d", d), 64'(done[d]), 64'd0);
      chk($sformatf("rst_werr_d%0d", d), 64'(werr[d]), 64'd0);
      chk($sformatf("rst_rdy_d%0d", d), 64'(rdy[d]), 64'd1);
    end
    nRst = 1'b1;
    tick();

    // Reset mid-RUN discards 5*7 on the LAT=2 instance.
    a = 32'd5; b = 32'd7; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("midrst_busy_before", 64'(busy[1]), 64'd1);
    #3 nRst = 1'b0;
    #1;
    chk("midrst_busy_async", 64'(busy[1]), 64'd0);
    chk("midrst_hilo_async", {hi[1], lo[1]}, 64'd0);
    tick();
    nRst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("midrst_nodone_%0d", j), 64'(done[1]), 64'd0);
      chk($sformatf("midrst_hilo_%0d", j), {hi[1], lo[1]}, 64'd0);
    end

    // Corner products at all three latencies.
    corner(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    corner(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    corner(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    corner(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    corner(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);

    // Back-to-back sweeps.
    sweep(1, 4096);
    sweep(0, 64);
    sweep(2, 64);

    // Stall: 2*3 held while 1*1 is in flight on the LAT=2 instance.
    a = 32'd1; b = 32'd1; start[1] = 1'b1;
    tick();
    a = 32'd2; b = 32'd3;
    tick();
    chk("stall_busy_hold", 64'(busy[1]), 64'd1);
    chk("stall_nodone_hold", 64'(done[1]), 64'd0);
    tick();
    chk("stall_done_first", 64'(done[1]), 64'd1);
    chk("stall_prod_first", {hi[1], lo[1]}, 64'd1);
    tick();
    start[1] = 1'b0;
    chk("stall_accept_busy", 64'(busy[1]), 64'd1);
    chk("stall_accept_nodone", 64'(done[1]), 64'd0);
    tick();
    chk("stall_run_busy", 64'(busy[1]), 64'd1);
    tick();
    chk("stall_done_second", 64'(done[1]), 64'd1);
    chk("stall_prod_second", {hi[1], lo[1]}, 64'd6);
    tick();
    chk("stall_single_done", 64'(done[1]), 64'd0);
    chk("stall_idle", 64'(busy[1]), 64'd0);

    // Idle direct writes: both, then HI alone.
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("wr_both_d%0d", d), {hi[d], lo[d]}, 64'hDEAD_BEEF_DEAD_BEEF);
      chk($sformatf("wr_both_noerr_d%0d", d), 64'(werr[d]), 64'd0);
    end
    lo_we = 1'b0; wr_data = 32'h1111_1111;
    tick();
    hi_we = 1'b0;
    chk("wr_hi_only", {hi[1], lo[1]}, 64'h1111_1111_DEAD_BEEF);

    // Write during RUN on LAT=2 is dropped; idle siblings take it.
    a = 32'hFFFF_FFFF; b = 32'd2; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("wr_run_err", 64'(werr[1]), 64'd1);
    chk("wr_run_hold", {hi[1], lo[1]}, 64'h1111_1111_DEAD_BEEF);
    chk("wr_idle_sib_noerr", 64'(werr[0]), 64'd0);
    chk("wr_idle_sib_data", {hi[0], lo[0]}, 64'hCAFE_F00D_CAFE_F00D);
    tick();
    chk("wr_run_err_pulse", 64'(werr[1]), 64'd0);
    chk("wr_run_done", 64'(done[1]), 64'd1);
    chk("wr_run_prod", {hi[1], lo[1]}, 64'hFFFF_FFFF_FFFF_FFFE);

    // Write coinciding with start acceptance on LAT=1 is dropped.
    a = 32'd3; b = 32'd4; start[0] = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5555_5555;
    tick();
    start[0] = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("wr_start_err", 64'(werr[0]), 64'd1);
    chk("wr_start_hold", {hi[0], lo[0]}, 64'hCAFE_F00D_CAFE_F00D);
    tick();
    chk("wr_start_done", 64'(done[0]), 64'd1);
    chk("wr_start_prod", {hi[0], lo[0]}, 64'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
